// File: rtl/cook_timer.sv
// cook_timer: MM:SS BCD cook-time register for the microwave controller.
// Digits are keyed in from the right while the magnetron is off. While it is on,
// the time counts down once every TICKS_PER_SEC clocks. timer_done is raised on
// the edge that reaches 00:00.
module cook_timer #(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clearn,
  input  logic       mag_on,
  input  logic       keypad_valid,
  input  logic [3:0] keypad_digit,
  output logic [3:0] min_tens,
  output logic [3:0] min_units,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic       time_zero,
  output logic       timer_done
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PSC_LAST = PW'(TICKS_PER_SEC - 1);

  logic [3:0]    mt_q, mu_q, st_q, su_q;
  logic [3:0]    mt_d, mu_d, st_d, su_d;
  logic [PW-1:0] psc_q, psc_d;
  logic          done_q, done_d;

  logic digits_zero;
  logic count_en;
  logic tick;
  logic key_ok;

  assign digits_zero = (mt_q == 4'd0) && (mu_q == 4'd0) && (st_q == 4'd0) && (su_q == 4'd0);
  // The prescaler only runs while cooking and not yet expired.
  assign count_en    = mag_on && !done_q;
  assign tick        = count_en && (psc_q == PSC_LAST);
  // Keys are ignored while cooking; codes above 9 are not digits.
  assign key_ok      = !mag_on && keypad_valid && (keypad_digit <= 4'd9);

  // Next-state: countdown/expiry takes precedence, otherwise keypad shift-in.
  always_comb begin
    mt_d   = mt_q;
    mu_d   = mu_q;
    st_d   = st_q;
    su_d   = su_q;
    psc_d  = psc_q;
    done_d = done_q;
    if (count_en) begin
      if (digits_zero) begin
        // Started at 00:00: expire immediately, prescaler parked at 0.
        done_d = 1'b1;
        psc_d  = '0;
      end else if (tick) begin
        psc_d = '0;
        if (su_q != 4'd0) begin
          su_d = su_q - 4'd1;
        end else if (st_q != 4'd0) begin
          st_d = st_q - 4'd1;
          su_d = 4'd9;
        end else begin
          // Minutes are nonzero here because the digits are not all zero.
          st_d = 4'd5;
          su_d = 4'd9;
          if (mu_q != 4'd0) begin
            mu_d = mu_q - 4'd1;
          end else begin
            mu_d = 4'd9;
            mt_d = mt_q - 4'd1;
          end
        end
        // Expiry on the same edge that lands on 00:00.
        done_d = (mt_d == 4'd0) && (mu_d == 4'd0) && (st_d == 4'd0) && (su_d == 4'd0);
      end else begin
        psc_d = psc_q + 1'b1;
      end
    end else if (key_ok) begin
      mt_d   = mu_q;
      mu_d   = st_q;
      st_d   = su_q;
      su_d   = keypad_digit;
      done_d = 1'b0;
    end
  end

  // State register: reset beats front-panel clear beats normal update.
  always_ff @(posedge clk) begin
    if (!resetn || !clearn) begin
      mt_q   <= 4'd0;
      mu_q   <= 4'd0;
      st_q   <= 4'd0;
      su_q   <= 4'd0;
      psc_q  <= '0;
      done_q <= 1'b0;
    end else begin
      mt_q   <= mt_d;
      mu_q   <= mu_d;
      st_q   <= st_d;
      su_q   <= su_d;
      psc_q  <= psc_d;
      done_q <= done_d;
    end
  end

  assign min_tens   = mt_q;
  assign min_units  = mu_q;
  assign sec_tens   = st_q;
  assign sec_units  = su_q;
  assign time_zero  = digits_zero;
  assign timer_done = done_q;

endmodule
